// File: rtl/half_add_serial_sched.sv
// Round-robin scheduler sharing one bit-serial adder (two chained half adders) between two requesters.
// Optional SERIAL_ADD_SUB_EN adds per-requester subtract (A-B via inverted B and carry-in of 1).
module half_add_serial_sched #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             req0_sub,
`endif
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             req1_sub,
`endif
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_id,
    input  logic             res_ready
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] sum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_gnt_q;

    logic             gnt;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_sub;
    logic             s1;
    logic             c1;
    logic             s;
    logic             c2;
    logic             cout;
    logic [WIDTH-1:0] sum_nxt;

    always_comb begin
        // Contention goes to the requester that did not win last time.
        gnt        = (req0_valid && req1_valid) ? ~last_gnt_q : req1_valid;
        req0_ready = (state_q == StIdle) && req0_valid && !gnt;
        req1_ready = (state_q == StIdle) && req1_valid && gnt;
        accept     = req0_ready || req1_ready;
        sel_a      = gnt ? req1_a : req0_a;
        sel_b      = gnt ? req1_b : req0_b;
`ifdef SERIAL_ADD_SUB_EN
        sel_sub    = gnt ? req1_sub : req0_sub;
`else
        sel_sub    = 1'b0;
`endif
        s1         = a_q[0] ^ b_q[0];
        c1         = a_q[0] & b_q[0];
        s          = s1 ^ carry_q;
        c2         = s1 & carry_q;
        cout       = c1 | c2;
        sum_nxt    = {s, sum_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            last_gnt_q <= 1'b1;
            res_valid  <= 1'b0;
            res_sum    <= '0;
            res_carry  <= 1'b0;
            res_id     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q        <= sel_a;
                        b_q        <= sel_sub ? ~sel_b : sel_b;
                        carry_q    <= sel_sub;
                        cnt_q      <= '0;
                        res_id     <= gnt;
                        last_gnt_q <= gnt;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum_q   <= sum_nxt[WIDTH-1:1];
                    carry_q <= cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        // Result registers only update here so they stay stable outside DONE.
                        res_sum   <= sum_nxt;
                        res_carry <= cout;
                        res_valid <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_half_add_serial_sched.sv
// Self-checking bench for half_add_serial_sched: table-driven ops, arbitration, backpressure and
// mid-operation reset, with a scoreboard of expected results popped on each result handshake.
module tb_half_add_serial_sched;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req0_sub = 1'b0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         req1_sub = 1'b0;
    logic         req1_ready;
    logic         res_valid;
    logic [W-1:0] res_sum;
    logic         res_carry;
    logic         res_id;
    logic         res_ready = 1'b0;

    half_add_serial_sched #(.WIDTH(W), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
`ifdef SERIAL_ADD_SUB_EN
        .req0_sub   (req0_sub),
`endif
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
`ifdef SERIAL_ADD_SUB_EN
        .req1_sub   (req1_sub),
`endif
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_sum    (res_sum),
        .res_carry  (res_carry),
        .res_id     (res_id),
        .res_ready  (res_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           sub;
        logic [W-1:0] sum;
        bit           carry;
    } vec_t;

    typedef struct {
        bit           id;
        logic [W-1:0] sum;
        bit           carry;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   prev_valid = 1'b0;
    exp_t sb[$];
    vec_t vecs[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Result checker: pops the scoreboard on every handshake and times accept -> res_valid.
    always @(negedge clk) begin
        exp_t e;
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_cyc = cyc;
        // Accept seen here lands on the next edge, so the rise is observed W+1 samples later.
        if (res_valid && !prev_valid) chk("latency", cyc - acc_cyc, W + 1);
        prev_valid = res_valid;
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got sum %0h id %0d, expected none", res_sum, res_id);
            end else begin
                e = sb.pop_front();
                chk("res_sum", res_sum, e.sum);
                chk("res_carry", res_carry, e.carry);
                chk("res_id", res_id, e.id);
            end
        end
    end

    task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                         input logic [W-1:0] es, input bit ec);
        int n = 0;
        @(posedge clk);
        #1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
        end
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no ready for req%0d, expected ready", id);
        end else begin
            sb.push_back('{id: id, sum: es, carry: ec});
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || res_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
        end
    endtask

    initial begin
        logic [W:0] r;
        int         ids[$];
        int         cycs[$];
        int         n;

        vecs.push_back('{id: 1'b0, a: 8'h0F, b: 8'h01, sub: 1'b0, sum: 8'h10, carry: 1'b0});
        vecs.push_back('{id: 1'b1, a: 8'hFF, b: 8'h01, sub: 1'b0, sum: 8'h00, carry: 1'b1});
        vecs.push_back('{id: 1'b0, a: 8'h80, b: 8'h80, sub: 1'b0, sum: 8'h00, carry: 1'b1});
        vecs.push_back('{id: 1'b0, a: 8'h7F, b: 8'h01, sub: 1'b0, sum: 8'h80, carry: 1'b0});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{id: 1'b0, a: 8'h05, b: 8'h07, sub: 1'b1, sum: 8'hFE, carry: 1'b0});
        vecs.push_back('{id: 1'b1, a: 8'h07, b: 8'h05, sub: 1'b1, sum: 8'h02, carry: 1'b1});
`endif
        vecs.push_back('{id: 1'b1, a: 8'hAA, b: 8'h55, sub: 1'b0, sum: 8'hFF, carry: 1'b0});

        // Reset and idle.
        res_ready = 1'b1;
        #23 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", {res_valid, res_sum, res_carry, res_id, req0_ready, req1_ready}, 0);
        end

        // Table-driven single operations; the last one is from req1 so req0 wins next.
        foreach (vecs[i]) begin
            issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].carry);
            drain();
        end

        // Both requesters valid continuously: alternate grants every W+2 cycles.
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h40; req1_b = 8'hC1; req1_sub = 1'b0;
        n = 0;
        while (ids.size() < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (req0_ready) begin
                ids.push_back(0);
                cycs.push_back(cyc);
                r = model(req0_a, req0_b, 1'b0);
                sb.push_back('{id: 1'b0, sum: r[W-1:0], carry: r[W]});
            end else if (req1_ready) begin
                ids.push_back(1);
                cycs.push_back(cyc);
                r = model(req1_a, req1_b, 1'b0);
                sb.push_back('{id: 1'b1, sum: r[W-1:0], carry: r[W]});
            end
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_accepts", ids.size(), 4);
        foreach (ids[i]) begin
            chk("rr_grant", ids[i], i % 2);
            if (i > 0) chk("rr_spacing", cycs[i] - cycs[i-1], W + 2);
        end
        drain();

        // Backpressure in DONE with both requesters asserting and operands changing.
        res_ready = 1'b0;
        issue(1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
        req1_valid = 1'b1; req1_a = 8'h9C; req1_b = 8'h64;
        n = 0;
        while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", res_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", res_valid, 1'b1);
            chk("bp_sum", res_sum, 8'h46);
            chk("bp_readies", {req0_ready, req1_ready}, 2'b00);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_accept", req1_ready, 1'b1);
        r = model(8'h9C, 8'h64, 1'b0);
        sb.push_back('{id: 1'b1, sum: r[W-1:0], carry: r[W]});
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        drain();

        // Reset in the middle of an operation discards it.
        issue(1'b0, 8'h33, 8'h44, 1'b0, 8'h77, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_sum", res_sum, 8'h00);
        chk("rst_res_carry", res_carry, 1'b0);
        chk("rst_res_id", res_id, 1'b0);
        chk("rst_readies", {req0_ready, req1_ready}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rst_no_result", res_valid, 1'b0);
        end
        r = model(8'h01, 8'h02, 1'b0);
        issue(1'b0, 8'h01, 8'h02, 1'b0, r[W-1:0], r[W]);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
